// File: rtl/cached_memory_if.sv
// Requester-side word port of cached_memory: address/data, read/write strobes, ready handshake.
interface cached_memory_if #(
    parameter int DATA_WIDTH = 64
);
    logic [63:0]           addr;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;
    logic                  re;
    logic                  we;
    logic                  ready;

    modport master (output addr, din, re, we, input dout, ready);
    modport slave  (input addr, din, re, we, output dout, ready);
endinterface

// File: rtl/cached_memory.sv
// Direct-mapped write-back/write-allocate cache over a fixed-latency word RAM model.
// Optional CACHED_MEMORY_STATS_EN adds hit_count/miss_count outputs.
module cached_memory #(
    parameter int DATA_WIDTH  = 64,
    parameter int LINE_SIZE   = 2,
    parameter int LINE_COUNT  = 128,
    parameter int RAM_WORDS   = 1024,
    parameter int RAM_LATENCY = 4
) (
    input  logic             clk,
    input  logic             rst,
    cached_memory_if.slave   bus
`ifdef CACHED_MEMORY_STATS_EN
    ,
    output logic [31:0]      hit_count,
    output logic [31:0]      miss_count
`endif
);
    localparam int OFF_W  = $clog2(LINE_SIZE);
    localparam int IDX_W  = $clog2(LINE_COUNT);
    localparam int TAG_W  = 64 - OFF_W - IDX_W;
    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int CNT_W  = $clog2(RAM_LATENCY + 1);

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FILL, DONE} state_t;

    state_t                state_q, state_d;
    logic [63:0]           addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d, dout_q, dout_d;
    logic                  wr_q, wr_d, ready_q, ready_d;
    logic [LINE_COUNT-1:0] valid_q, valid_d, dirty_q, dirty_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [OFF_W-1:0]      wi_q, wi_d;
    logic [31:0]           hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    // Storage arrays are not reset; the RAM model powers up as all-ones.
    logic [DATA_WIDTH-1:0] data_mem [LINE_COUNT*LINE_SIZE];
    logic [TAG_W-1:0]      tag_mem  [LINE_COUNT];
    logic [DATA_WIDTH-1:0] ram      [RAM_WORDS] = '{default: {DATA_WIDTH{1'b1}}};

    logic [OFF_W-1:0]        off;
    logic [IDX_W-1:0]        idx;
    logic [TAG_W-1:0]        tag;
    logic                    hit, last_beat, last_word;
    logic                    mem_we, ram_we, tag_we;
    logic [OFF_W+IDX_W-1:0]  mem_wa;
    logic [DATA_WIDTH-1:0]   mem_wd, ram_wd;
    logic [RAM_AW-1:0]       ram_wa;

    assign off       = addr_q[OFF_W-1:0];
    assign idx       = addr_q[OFF_W +: IDX_W];
    assign tag       = addr_q[63 -: TAG_W];
    assign hit       = valid_q[idx] && (tag_mem[idx] == tag);
    assign last_beat = (cnt_q == CNT_W'(RAM_LATENCY - 1));
    assign last_word = (wi_q == OFF_W'(LINE_SIZE - 1));

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        din_d      = din_q;
        wr_d       = wr_q;
        ready_d    = ready_q;
        dout_d     = dout_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        cnt_d      = cnt_q;
        wi_d       = wi_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        mem_we     = 1'b0;
        mem_wa     = {idx, off};
        mem_wd     = din_q;
        ram_we     = 1'b0;
        ram_wa     = RAM_AW'({tag_mem[idx], idx, wi_q});
        ram_wd     = data_mem[{idx, wi_q}];
        tag_we     = 1'b0;
        case (state_q)
            IDLE: if (bus.re || bus.we) begin
                addr_d  = bus.addr;
                din_d   = bus.din;
                wr_d    = bus.we;
                ready_d = 1'b0;
                state_d = LOOKUP;
            end
            LOOKUP: begin
                cnt_d = '0;
                wi_d  = '0;
                if (hit) begin
                    hit_cnt_d = hit_cnt_q + 32'd1;
                    if (wr_q) begin
                        mem_we       = 1'b1;
                        dirty_d[idx] = 1'b1;
                    end else begin
                        dout_d = data_mem[{idx, off}];
                    end
                    ready_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    miss_cnt_d = miss_cnt_q + 32'd1;
                    state_d    = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : FILL;
                end
            end
            WRITEBACK, FILL: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (last_beat) begin
                    if (state_q == WRITEBACK) begin
                        ram_we = 1'b1;
                    end else begin
                        mem_we = 1'b1;
                        mem_wa = {idx, wi_q};
                        mem_wd = ram[RAM_AW'({addr_q[63:OFF_W], wi_q})];
                    end
                    cnt_d = '0;
                    wi_d  = wi_q + OFF_W'(1);
                    if (last_word) state_d = (state_q == WRITEBACK) ? FILL : DONE;
                end
            end
            DONE: begin
                // Line is fully filled; finish the access exactly like a hit.
                tag_we       = 1'b1;
                valid_d[idx] = 1'b1;
                dirty_d[idx] = wr_q;
                if (wr_q) mem_we = 1'b1;
                else      dout_d = data_mem[{idx, off}];
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            din_q      <= '0;
            wr_q       <= 1'b0;
            ready_q    <= 1'b1;
            dout_q     <= '0;
            valid_q    <= '0;
            dirty_q    <= '0;
            cnt_q      <= '0;
            wi_q       <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            wr_q       <= wr_d;
            ready_q    <= ready_d;
            dout_q     <= dout_d;
            valid_q    <= valid_d;
            dirty_q    <= dirty_d;
            cnt_q      <= cnt_d;
            wi_q       <= wi_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Array writes are suppressed during reset so an aborted miss leaves RAM untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (mem_we) data_mem[mem_wa] <= mem_wd;
            if (ram_we) ram[ram_wa]      <= ram_wd;
            if (tag_we) tag_mem[idx]     <= tag;
        end
    end

    assign bus.ready = ready_q;
    assign bus.dout  = dout_q;

`ifdef CACHED_MEMORY_STATS_EN
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif
endmodule

// File: tb/tb_cached_memory.sv
// Directed bench for cached_memory: hit/miss latency, writeback ordering, dout hold, reset abort.
module tb_cached_memory;
    localparam int L = 4;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] K    = 64'h0123_4567_89ab_cdef;
    localparam int HIT = 1, CLEAN = 2 + 2*L, DIRTY = 2 + 4*L;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0, n_pass = 0, n_acc = 0;
`ifdef CACHED_MEMORY_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    cached_memory_if #(.DATA_WIDTH(64)) bus ();

    cached_memory #(.DATA_WIDTH(64), .LINE_SIZE(2), .LINE_COUNT(128),
                    .RAM_WORDS(1024), .RAM_LATENCY(L)) dut (
        .clk(clk), .rst(rst), .bus(bus)
`ifdef CACHED_MEMORY_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    endtask

    // One request; lat = edges after acceptance until ready returns high.
    task automatic acc(input string nm, input bit wr, input logic [63:0] a, input logic [63:0] d,
                       input int lat, input logic [63:0] exp_dout);
        int n;
        @(negedge clk);
        bus.addr = a; bus.din = d; bus.re = !wr; bus.we = wr;
        @(posedge clk); #1;
        bus.re = 1'b0; bus.we = 1'b0;
        n_acc++;
        n = 0;
        while (!bus.ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, " latency"}, 64'(n), 64'(lat));
        chk({nm, " dout"}, bus.dout, exp_dout);
    endtask

    initial begin
        bus.addr = '0; bus.din = '0; bus.re = 1'b0; bus.we = 1'b0;
        // 1. reset
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("reset ready", 64'(bus.ready), 64'd1);
        chk("reset dout", bus.dout, 64'd0);
`ifdef CACHED_MEMORY_STATS_EN
        chk("reset counters", 64'(hit_count + miss_count), 64'd0);
`endif
        // 2. clean miss, hits
        acc("wr1 clean miss", 1, 64'd1, K, CLEAN, 64'd0);
        acc("rd1 hit", 0, 64'd1, 0, HIT, K);
        acc("rd0 hit init", 0, 64'd0, 0, HIT, ONES);
        // 3. conflict on index 0 with dirty victim
        acc("wr257 dirty miss", 1, 64'd257, 64'd123, DIRTY, ONES);
        acc("rd257 hit", 0, 64'd257, 0, HIT, 64'd123);
        // 4. ping-pong between tags 0 and 1
        acc("rd1 dirty miss", 0, 64'd1, 0, DIRTY, K);
        acc("wr256 clean miss", 1, 64'd256, 64'd321, CLEAN, K);
        acc("rd257 hit2", 0, 64'd257, 0, HIT, 64'd123);
        acc("rd1 dirty miss2", 0, 64'd1, 0, DIRTY, K);
        acc("rd256 clean miss", 0, 64'd256, 0, CLEAN, 64'd321);
        // 5. overwrite then evict
        acc("wr1 clean miss2", 1, 64'd1, 64'd5, CLEAN, 64'd321);
        acc("rd1 hit5", 0, 64'd1, 0, HIT, 64'd5);
        acc("rd257 dirty miss", 0, 64'd257, 0, DIRTY, 64'd123);
        acc("rd256 hit", 0, 64'd256, 0, HIT, 64'd321);
`ifdef CACHED_MEMORY_STATS_EN
        chk("stats sum", 64'(hit_count + miss_count), 64'(n_acc));
`endif
        // 6. reset during FILL of address 10
        @(negedge clk);
        bus.addr = 64'd10; bus.re = 1'b1;
        @(posedge clk); #1;
        bus.re = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk("abort ready", 64'(bus.ready), 64'd1);
        chk("abort dout", bus.dout, 64'd0);
        n_acc = 0;
        acc("rd10 after abort", 0, 64'd10, 0, CLEAN, ONES);
        acc("rd1 after reset", 0, 64'd1, 0, CLEAN, 64'd5);
        acc("rd256 after reset", 0, 64'd256, 0, CLEAN, 64'd321);
        acc("rd257 after reset", 0, 64'd257, 0, HIT, 64'd123);
`ifdef CACHED_MEMORY_STATS_EN
        chk("stats after reset", 64'(miss_count), 64'd3);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
